// File: rtl/tile_pkg.sv
// Shared definitions for the tiled matrix writer and its matching tiled reader.
package tile_pkg;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } wr_state_e;

   function automatic int unsigned tiles_per_dim(input int unsigned w, input int unsigned b);
      return w / b;
   endfunction

   // Flat bit position of tile (ti,tj) element (r,c) in a w x w matrix.
   function automatic int unsigned tile_bit_index(input int unsigned ti, input int unsigned tj,
                                                  input int unsigned r, input int unsigned c,
                                                  input int unsigned w, input int unsigned b);
      return (ti * b + r) * w + tj * b + c;
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tile_index_counter.sv
// 2-D wrapping tile position counter, tile column innermost.
module tile_index_counter
   import tile_pkg::*;
#(
   parameter int unsigned T  = 4,
   parameter int unsigned CW = idx_width(T)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] ti_o,
   output logic [CW-1:0] tj_o,
   output logic          last_o
);

   logic [CW-1:0] ti_q, ti_d;
   logic [CW-1:0] tj_q, tj_d;

   always_comb begin
      ti_d = ti_q;
      tj_d = tj_q;
      if (clr) begin
         ti_d = '0;
         tj_d = '0;
      end else if (inc) begin
         if (tj_q == CW'(T - 1)) begin
            tj_d = '0;
            ti_d = (ti_q == CW'(T - 1)) ? '0 : ti_q + CW'(1);
         end else begin
            tj_d = tj_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ti_q <= '0;
         tj_q <= '0;
      end else begin
         ti_q <= ti_d;
         tj_q <= tj_d;
      end
   end

   assign ti_o   = ti_q;
   assign tj_o   = tj_q;
   assign last_o = (ti_q == CW'(T - 1)) && (tj_q == CW'(T - 1));

endmodule

// File: rtl/tile_matrix_writer.sv
// Fills a W x W bit matrix from a row-major stream of B x B tiles and hands it
// downstream over valid/ready; flags tile_last disagreeing with the tile position.
module tile_matrix_writer
   import tile_pkg::*;
#(
   parameter int unsigned W = 16,
   parameter int unsigned B = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tile_valid,
   output logic             tile_ready,
   input  logic [B*B-1:0]   tile_data,
   input  logic             tile_last,
   input  logic             abort,
   output logic [W*W-1:0]   a_data,
   output logic             a_valid,
   input  logic             a_ready,
   output logic             proto_err
);

   localparam int unsigned T  = tiles_per_dim(W, B);
   localparam int unsigned CW = idx_width(T);

   if ((W % B) != 0) begin : g_bad_dims
      $error("tile_matrix_writer: W must be a multiple of B");
   end

   wr_state_e      state_q, state_d;
   logic           tile_ready_q, tile_ready_d;
   logic           a_valid_q, a_valid_d;
   logic           proto_err_q, proto_err_d;
   logic [W*W-1:0] a_data_q, a_data_d;
   logic           accept;
   logic           wr;
   logic           cnt_inc;
   logic           cnt_clr;
   logic [CW-1:0]  ti;
   logic [CW-1:0]  tj;
   logic           last_tile;
   logic [T*T-1:0] tile_we;

   tile_index_counter #(.T(T), .CW(CW)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (cnt_inc),
      .clr    (cnt_clr),
      .ti_o   (ti),
      .tj_o   (tj),
      .last_o (last_tile)
   );

   assign accept = tile_valid && tile_ready_q;

   always_comb begin
      state_d      = state_q;
      tile_ready_d = 1'b0;
      a_valid_d    = a_valid_q;
      proto_err_d  = proto_err_q;
      wr           = 1'b0;
      cnt_inc      = 1'b0;
      cnt_clr      = 1'b0;
      case (state_q)
         FILL: begin
            // abort wins over a same-cycle tile, which is dropped unchecked
            if (abort) begin
               cnt_clr = 1'b1;
            end else if (accept) begin
               wr      = 1'b1;
               cnt_inc = 1'b1;
               if (tile_last != last_tile) begin
                  proto_err_d = 1'b1;
               end
               if (last_tile) begin
                  state_d   = FULL;
                  a_valid_d = 1'b1;
               end
            end
         end
         FULL: begin
            if (a_valid_q && a_ready) begin
               state_d   = FILL;
               a_valid_d = 1'b0;
            end
         end
         default: state_d = FILL;
      endcase
      tile_ready_d = (state_d == FILL);
   end

   // Each tile row is a contiguous B-bit slice of the flat matrix.
   for (genvar gi = 0; gi < T; gi++) begin : g_ti
      for (genvar gj = 0; gj < T; gj++) begin : g_tj
         assign tile_we[gi*T+gj] = wr && (ti == CW'(gi)) && (tj == CW'(gj));
         for (genvar gr = 0; gr < B; gr++) begin : g_row
            localparam int unsigned BASE = tile_bit_index(gi, gj, gr, 0, W, B);
            assign a_data_d[BASE +: B] = tile_we[gi*T+gj] ? tile_data[gr*B +: B]
                                                          : a_data_q[BASE +: B];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FILL;
         tile_ready_q <= 1'b0;
         a_valid_q    <= 1'b0;
         proto_err_q  <= 1'b0;
         a_data_q     <= '0;
      end else begin
         state_q      <= state_d;
         tile_ready_q <= tile_ready_d;
         a_valid_q    <= a_valid_d;
         proto_err_q  <= proto_err_d;
         a_data_q     <= a_data_d;
      end
   end

   assign tile_ready = tile_ready_q;
   assign a_valid    = a_valid_q;
   assign proto_err  = proto_err_q;
   assign a_data     = a_data_q;

endmodule

// File: tb/tb_tile_matrix_writer.sv
// Self-checking bench for tile_matrix_writer (W=16, B=4) with a matrix scoreboard.
module tb_tile_matrix_writer;

   localparam int unsigned W = 16;
   localparam int unsigned B = 4;
   localparam int unsigned T = W / B;
   localparam int unsigned N = W * W;

   logic           clk;
   logic           rst;
   logic           tile_valid;
   logic           tile_ready;
   logic [B*B-1:0] tile_data;
   logic           tile_last;
   logic           abort;
   logic [N-1:0]   a_data;
   logic           a_valid;
   logic           a_ready;
   logic           proto_err;

   int n_checks;
   int n_errors;

   logic [N-1:0] sb_q[$];
   logic [N-1:0] m_a;
   int           m_ti;
   int           m_tj;
   bit           m_full;
   bit           m_perr;
   logic [N-1:0] ident;

   tile_matrix_writer #(.W(W), .B(B)) dut (
      .clk        (clk),
      .rst        (rst),
      .tile_valid (tile_valid),
      .tile_ready (tile_ready),
      .tile_data  (tile_data),
      .tile_last  (tile_last),
      .abort      (abort),
      .a_data     (a_data),
      .a_valid    (a_valid),
      .a_ready    (a_ready),
      .proto_err  (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model and scoreboard, updated at the negedge preceding each edge.
   always @(negedge clk) begin
      if (rst) begin
         m_a    = '0;
         m_ti   = 0;
         m_tj   = 0;
         m_full = 1'b0;
         m_perr = 1'b0;
         sb_q.delete();
      end else begin
         check("proto_err_track", N'(proto_err), N'(m_perr));
         if (a_valid && a_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_matrix", N'(a_valid), N'(0));
            end else begin
               check("sb_matrix", a_data, sb_q.pop_front());
            end
            m_full = 1'b0;
         end else if (!m_full && abort) begin
            m_ti = 0;
            m_tj = 0;
         end else if (!m_full && tile_valid && tile_ready) begin
            for (int r = 0; r < B; r++)
               for (int c = 0; c < B; c++)
                  m_a[(m_ti*B+r)*W + m_tj*B + c] = tile_data[r*B+c];
            if (tile_last != ((m_ti == T-1) && (m_tj == T-1))) m_perr = 1'b1;
            if ((m_ti == T-1) && (m_tj == T-1)) begin
               sb_q.push_back(m_a);
               m_full = 1'b1;
               m_ti   = 0;
               m_tj   = 0;
            end else if (m_tj == T-1) begin
               m_tj = 0;
               m_ti = m_ti + 1;
            end else begin
               m_tj = m_tj + 1;
            end
         end
      end
   end

   // Called and returns at posedge+1; waited = negedges spent with tile_ready low.
   task automatic send_tile(input logic [B*B-1:0] d, input logic l, output int waited);
      tile_valid = 1'b1;
      tile_data  = d;
      tile_last  = l;
      waited     = 0;
      forever begin
         @(negedge clk);
         if (tile_ready) begin
            @(posedge clk);
            #1;
            break;
         end
         waited++;
         if (waited > 50) begin
            check("accept_timeout", N'(tile_ready), N'(1));
            break;
         end
      end
      tile_valid = 1'b0;
      tile_last  = 1'b0;
   endtask

   task automatic drain();
      int n;
      a_ready = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (a_valid && n < 30);
      check("drain_a_valid_low", N'(a_valid), N'(0));
      a_ready = 1'b0;
   endtask

   initial begin
      int w;
      logic [B*B-1:0] d;
      rst = 1'b1; tile_valid = 1'b0; tile_data = '0; tile_last = 1'b0;
      abort = 1'b0; a_ready = 1'b0;
      n_checks = 0; n_errors = 0;
      ident = '0;
      for (int i = 0; i < W; i++) ident[i*(W+1)] = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_tile_ready", N'(tile_ready), N'(0));
      check("rst_a_valid", N'(a_valid), N'(0));
      check("rst_a_data", a_data, '0);
      check("rst_proto_err", N'(proto_err), N'(0));
      rst = 1'b0;
      #1;
      check("rel_tile_ready_pre_edge", N'(tile_ready), N'(0));
      @(posedge clk);
      #1;
      check("rel_tile_ready_post_edge", N'(tile_ready), N'(1));

      // Identity fill
      for (int k = 0; k < T*T; k++) begin
         d = ((k / T) == (k % T)) ? 16'h8421 : 16'h0000;
         send_tile(d, k == T*T-1, w);
         if (k == T*T-2) check("ident_a_valid_early", N'(a_valid), N'(0));
      end
      check("ident_a_valid", N'(a_valid), N'(1));
      check("ident_tile_ready_full", N'(tile_ready), N'(0));
      check("ident_a_data", a_data, ident);

      // Backpressure with the next matrix's first tile waiting
      tile_valid = 1'b1; tile_data = 16'hFFFF; tile_last = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_tile_ready", N'(tile_ready), N'(0));
         check("bp_a_data_stable", a_data, ident);
      end
      @(posedge clk);
      #1;
      a_ready = 1'b1;
      @(posedge clk);
      #1;
      a_ready = 1'b0;
      check("bp_a_valid_drop", N'(a_valid), N'(0));
      check("bp_tile_ready_back", N'(tile_ready), N'(1));
      send_tile(16'hFFFF, 1'b0, w);
      check("bp_first_accept_wait", N'(w), N'(0));

      // Overwrite with all-ones
      for (int k = 1; k < T*T; k++) send_tile(16'hFFFF, k == T*T-1, w);
      check("ones_a_data", a_data, {N{1'b1}});
      drain();

      // Abort after 7 tiles; a same-cycle tile is dropped
      for (int k = 0; k < 7; k++) send_tile(16'h1234, 1'b0, w);
      abort = 1'b1; tile_valid = 1'b1; tile_data = 16'h5555;
      @(posedge clk);
      #1;
      abort = 1'b0; tile_valid = 1'b0;
      for (int k = 0; k < T*T; k++) begin
         send_tile(16'hFFFF ^ B*B'(k * 16'h0101), k == T*T-1, w);
         if (k == 0) check("abort_tile00", N'(a_data[B-1:0]), N'(4'hF));
         if (k == T*T-2) check("abort_a_valid_early", N'(a_valid), N'(0));
      end
      check("abort_a_valid", N'(a_valid), N'(1));
      check("abort_proto_err", N'(proto_err), N'(0));
      drain();

      // Protocol error on the third tile; abort while FULL is ignored
      for (int k = 0; k < T*T; k++) begin
         send_tile(B*B'($urandom), (k == 2) || (k == T*T-1), w);
         if (k == 2) check("perr_set", N'(proto_err), N'(1));
      end
      check("perr_a_valid", N'(a_valid), N'(1));
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("full_abort_ignored", N'(a_valid), N'(1));
      drain();
      check("perr_sticky", N'(proto_err), N'(1));

      // Mid-operation asynchronous reset, then a clean matrix
      for (int k = 0; k < 5; k++) send_tile(B*B'($urandom), 1'b0, w);
      rst = 1'b1;
      #1;
      check("mid_rst_tile_ready", N'(tile_ready), N'(0));
      check("mid_rst_a_data", a_data, '0);
      check("mid_rst_proto_err", N'(proto_err), N'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < T*T; k++) send_tile(B*B'($urandom), k == T*T-1, w);
      check("post_rst_a_valid", N'(a_valid), N'(1));
      drain();
      check("sb_empty", N'(sb_q.size()), N'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
